ph_fifo: RTL and testbench

PH_FIFO -- requirements
Module: ph_fifo

---
 rtl/tube_pkg.sv | 14 +
 rtl/ph_fifo_ram.sv | 21 ++
 rtl/ph_fifo.sv | 77 +++++++
 tb/tb_ph_fifo.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared widths and defaults for the tube data FIFOs, plus pointer wrap helper.
package tube_pkg;
  localparam int BYTE_W    = 8;
  localparam int DEPTH_DEF = 24;
  localparam int PTR_W     = 5;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  // Depth is not necessarily a power of two, so wrap explicitly.
  function automatic ptr_t ptr_next(input ptr_t p, input int depth);
    return (p == ptr_t'(depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction
endpackage

// File: rtl/ph_fifo_ram.sv
// DEPTH x 8 storage: synchronous write, asynchronous read.
module ph_fifo_ram
  import tube_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic  h_phi2,
  input  logic  i_we,
  input  ptr_t  i_waddr,
  input  byte_t i_wdata,
  input  ptr_t  i_raddr,
  output byte_t o_rdata
);
  byte_t r_mem [DEPTH];

  always_ff @(posedge h_phi2) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ph_fifo.sv
// Parasite-to-host byte FIFO with normal and two-byte handshake modes.
module ph_fifo
  import tube_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        h_phi2,
  input  logic        h_rst_b,
  input  logic        p_phi2_en,
  input  logic        p_selectData,
  input  logic        p_rdnw,
  input  logic [7:0]  p_data,
  input  logic        p_two_byte,
  input  logic        h_phi2_en,
  input  logic        h_selectData,
  input  logic        h_rdnw,
  output logic [7:0]  h_data,
  output logic        h_data_available,
  output logic        p_full,
  output logic        p_overflow
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  ptr_t             r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_mode;
  logic             r_overflow;

  logic  w_wr_req, w_push, w_pop, w_flush;
  byte_t w_rd_data;

  assign w_wr_req = p_phi2_en & p_selectData & ~p_rdnw;
  // p_full comes from the registered count, so a same-cycle pop cannot free a slot.
  assign w_push   = w_wr_req & ~p_full;
  assign w_pop    = h_phi2_en & h_selectData & h_rdnw & (r_count != '0);
  assign w_flush  = (p_two_byte != r_mode);

  ph_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .h_phi2  (h_phi2),
    .i_we    (w_push & ~w_flush),
    .i_waddr (r_wr_ptr),
    .i_wdata (p_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge h_phi2) begin
    if (!h_rst_b) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_mode     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_mode <= p_two_byte;
      if (w_wr_req & p_full) r_overflow <= 1'b1;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr, DEPTH);
        if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr, DEPTH);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign h_data           = (r_count != '0) ? w_rd_data : 8'h00;
  assign h_data_available = r_mode ? (r_count >= CNT_W'(2)) : (r_count != '0);
  assign p_full           = r_mode ? (r_count >= CNT_W'(2)) : (r_count == CNT_W'(DEPTH));
  assign p_overflow       = r_overflow;
endmodule

// File: tb/tb_ph_fifo.sv
// Directed and random stimulus for ph_fifo, checked against a queue-based model.
module tb_ph_fifo;
  localparam int DEPTH = 24;

  logic       h_phi2 = 1'b0;
  logic       h_rst_b;
  logic       p_phi2_en, p_selectData, p_rdnw, p_two_byte;
  logic [7:0] p_data;
  logic       h_phi2_en, h_selectData, h_rdnw;
  logic [7:0] h_data;
  logic       h_data_available, p_full, p_overflow;

  int checks = 0;
  int passed = 0;

  // Model state: byte queue, current mode, sticky overflow.
  byte unsigned m_q[$];
  bit           m_mode = 0;
  bit           m_ovf  = 0;

  always #5 h_phi2 = ~h_phi2;

  ph_fifo #(.DEPTH(DEPTH)) dut (
    .h_phi2           (h_phi2),
    .h_rst_b          (h_rst_b),
    .p_phi2_en        (p_phi2_en),
    .p_selectData     (p_selectData),
    .p_rdnw           (p_rdnw),
    .p_data           (p_data),
    .p_two_byte       (p_two_byte),
    .h_phi2_en        (h_phi2_en),
    .h_selectData     (h_selectData),
    .h_rdnw           (h_rdnw),
    .h_data           (h_data),
    .h_data_available (h_data_available),
    .p_full           (p_full),
    .p_overflow       (p_overflow)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, got, exp);
  endtask

  function automatic bit m_full();
    return m_mode ? (m_q.size() >= 2) : (m_q.size() == DEPTH);
  endfunction

  // One clock: model the edge from the spec rules, then compare all outputs.
  task automatic tick(input string tag);
    bit         wq, rq, full_pre;
    logic [7:0] e_data;
    wq       = p_phi2_en && p_selectData && !p_rdnw;
    rq       = h_phi2_en && h_selectData && h_rdnw;
    full_pre = m_full();
    @(posedge h_phi2);
    if (!h_rst_b) begin
      m_q.delete();
      m_mode = 0;
      m_ovf  = 0;
    end else begin
      if (wq && full_pre) m_ovf = 1;
      if (p_two_byte != m_mode) begin
        m_q.delete();
        m_mode = p_two_byte;
      end else begin
        if (rq && m_q.size() > 0) void'(m_q.pop_front());
        if (wq && !full_pre) m_q.push_back(p_data);
      end
    end
    #1;
    e_data = (m_q.size() > 0) ? m_q[0] : 8'h00;
    chk({tag, ".h_data"}, h_data, e_data);
    chk({tag, ".avail"}, {7'd0, h_data_available},
        {7'd0, m_mode ? (m_q.size() >= 2) : (m_q.size() >= 1)});
    chk({tag, ".full"}, {7'd0, p_full}, {7'd0, m_full()});
    chk({tag, ".ovf"}, {7'd0, p_overflow}, {7'd0, m_ovf});
    $display("%s: q=%0d mode=%0d h_data=%02h avail=%0d full=%0d ovf=%0d",
             tag, m_q.size(), m_mode, h_data, h_data_available, p_full, p_overflow);
  endtask

  task automatic set_idle();
    p_phi2_en = 1; h_phi2_en = 1; p_rdnw = 0; h_rdnw = 1;
    p_selectData = 0; h_selectData = 0;
  endtask

  task automatic do_op(input bit w, input bit r, input logic [7:0] d, input string tag);
    p_selectData = w; h_selectData = r; p_data = d;
    tick(tag);
    set_idle();
  endtask

  initial begin
    set_idle();
    p_data = 8'h00; p_two_byte = 0; h_rst_b = 0;
    #2;
    tick("reset0");
    tick("reset1");
    h_rst_b = 1;
    do_op(0, 0, 8'h00, "idle");

    // Single byte round trip
    do_op(1, 0, 8'hA5, "pushA5");
    chk("a5_value", h_data, 8'hA5);
    do_op(0, 1, 8'h00, "popA5");
    chk("a5_avail_after_pop", {7'd0, h_data_available}, 8'h00);

    // Fill to DEPTH, overflow, drain in order
    for (int i = 1; i <= DEPTH; i++) do_op(1, 0, 8'(i), "fill");
    chk("full_at_depth", {7'd0, p_full}, 8'h01);
    do_op(1, 0, 8'hFF, "push_when_full");
    chk("ovf_set", {7'd0, p_overflow}, 8'h01);
    do_op(1, 1, 8'hEE, "push_pop_when_full");
    for (int i = 2; i <= DEPTH; i++) begin
      chk("drain_order", h_data, 8'(i));
      do_op(0, 1, 8'h00, "drain");
    end
    do_op(0, 1, 8'h00, "pop_empty");

    // Interleaved traffic wrapping the pointers
    do_op(1, 0, 8'h80, "prime");
    for (int i = 0; i < 40; i++) do_op(1, 1, 8'(8'h81 + i), "pushpop");
    do_op(0, 1, 8'h00, "drain_last");

    // Two-byte mode
    p_two_byte = 1;
    do_op(0, 0, 8'h00, "mode2_flush");
    do_op(1, 0, 8'h11, "m2_push11");
    chk("m2_avail_one", {7'd0, h_data_available}, 8'h00);
    do_op(1, 0, 8'h22, "m2_push22");
    chk("m2_full_two", {7'd0, p_full}, 8'h01);
    do_op(1, 0, 8'h33, "m2_push_refused");
    do_op(0, 1, 8'h00, "m2_pop");
    do_op(0, 1, 8'h00, "m2_pop2");

    // Mode change flushes queued bytes; mode change overrides a push
    p_two_byte = 0;
    do_op(1, 0, 8'h44, "mode1_flush_push");
    for (int i = 0; i < 3; i++) do_op(1, 0, 8'(8'h50 + i), "q3");
    p_two_byte = 1;
    do_op(0, 1, 8'h00, "toggle_flush");
    chk("flush_h_data", h_data, 8'h00);
    do_op(0, 1, 8'h00, "pop_after_flush");
    p_two_byte = 0;
    do_op(0, 0, 8'h00, "mode1_back");

    // Reset mid-stream with a simultaneous push
    for (int i = 0; i < 5; i++) do_op(1, 0, 8'(8'h60 + i), "q5");
    h_rst_b = 0;
    do_op(1, 0, 8'h77, "rst_with_push");
    chk("rst_avail", {7'd0, h_data_available}, 8'h00);
    h_rst_b = 1;
    do_op(0, 0, 8'h00, "post_rst");

    // Random traffic including unqualified cycles, mode toggles, resets
    for (int n = 0; n < 400; n++) begin
      p_phi2_en    = ($urandom_range(0, 7) != 0);
      h_phi2_en    = ($urandom_range(0, 7) != 0);
      p_rdnw       = ($urandom_range(0, 9) == 0);
      h_rdnw       = ($urandom_range(0, 9) != 0);
      p_selectData = ($urandom_range(0, 2) != 0);
      h_selectData = ($urandom_range(0, 2) == 0);
      p_data       = 8'($urandom);
      if ($urandom_range(0, 59) == 0) p_two_byte = ~p_two_byte;
      h_rst_b      = ($urandom_range(0, 149) != 0);
      tick("rand");
      h_rst_b = 1;
    end
    set_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
